// File: rtl/shift_tx_sched.sv
// shift_tx_sched: round-robin arbiter feeding one parallel-load serial shifter
// with a load strobe, WIDTH divided shift pulses, an empty check and a frame gap.
module shift_tx_sched #(
    parameter int WIDTH = 8,
    parameter int N     = 2,
    parameter int DIV   = 4,
    parameter int GAP   = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N-1:0]                      req_valid,
    input  logic [N*WIDTH-1:0]                req_data,
    output logic [N-1:0]                      req_ready,
    output logic [WIDTH-1:0]                  sh_data,
    output logic                              sh_write,
    output logic                              sh_clk,
    input  logic                              sh_empty,
    output logic                              busy,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] grant_id,
    output logic                              err
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int DW = $clog2(DIV + 1);
    localparam int PW = $clog2(WIDTH + 1);
    localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(DIV - 2);
    localparam logic [PW-1:0] PLS_LAST = PW'(WIDTH);
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CHECK, S_GAP} state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [PW-1:0]     pls_q, pls_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IW-1:0]     gid_q, gid_d, win, idx;
    logic              write_q, write_d, clk_q, clk_d, busy_q, busy_d, err_q, err_d;

    // Scan downward so the closest requester after the last grant wins.
    always_comb begin
        win = gid_q;
        idx = gid_q;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(gid_q) + k) % N);
            if (req_valid[idx]) win = idx;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pls_d     = pls_q;
        gap_d     = gap_q;
        data_d    = data_q;
        gid_d     = gid_q;
        err_d     = err_q;
        clk_d     = 1'b0;
        req_ready = '0;
        case (state_q)
            S_IDLE: if (|req_valid) begin
                req_ready[win] = 1'b1;
                data_d         = req_data[win*WIDTH +: WIDTH];
                gid_d          = win;
                state_d        = S_LOAD;
            end
            S_LOAD: begin
                div_d   = '0;
                pls_d   = '0;
                state_d = S_SHIFT;
            end
            // Pulse is registered, so it is requested one divider step early.
            S_SHIFT: begin
                div_d   = div_q == DIV_LAST ? '0 : div_q + 1'b1;
                clk_d   = div_q == DIV_PRE && pls_q != PLS_LAST;
                pls_d   = pls_q + PW'(clk_d);
                state_d = pls_q == PLS_LAST ? S_CHECK : S_SHIFT;
            end
            S_CHECK: begin
                err_d   = err_q | ~sh_empty;
                gap_d   = GAP_INIT;
                state_d = GAP == 0 ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                gap_d   = gap_q - 1'b1;
                state_d = gap_q == GW'(1) ? S_IDLE : S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
        write_d = state_d == S_LOAD;
        busy_d  = state_d != S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            pls_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            gid_q   <= IW'(N - 1);
            write_q <= 1'b0;
            clk_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pls_q   <= pls_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            write_q <= write_d;
            clk_q   <= clk_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign sh_data  = data_q;
    assign sh_write = write_q;
    assign sh_clk   = clk_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;
    assign err      = err_q;
endmodule

// File: tb/tb_shift_tx_sched.sv
// tb_shift_tx_sched: directed checks of grant timing, pulse train, round robin,
// error flag, mid-frame reset and a fast no-gap configuration.
module tb_shift_tx_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0, req_ready;
    logic [15:0] req_data = '0;
    logic [7:0]  sh_data;
    logic        sh_write, sh_clk, sh_empty, busy, err;
    logic [0:0]  grant_id;
    logic [1:0]  v1 = 2'b01, r1;
    logic [7:0]  d1;
    logic        w1, c1, b1, e1;
    logic [0:0]  g1;
    int          cyc = -1, n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    shift_tx_sched #(.WIDTH(8), .N(2), .DIV(4), .GAP(2)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .sh_data(sh_data), .sh_write(sh_write), .sh_clk(sh_clk),
        .sh_empty(sh_empty), .busy(busy), .grant_id(grant_id), .err(err));

    shift_tx_sched #(.WIDTH(8), .N(2), .DIV(2), .GAP(0)) u1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_data(16'h0077),
        .req_ready(r1), .sh_data(d1), .sh_write(w1), .sh_clk(c1),
        .sh_empty(1'b1), .busy(b1), .grant_id(g1), .err(e1));

    // Shifter model: MSB first, empty once all loaded bits have been shifted out.
    logic [7:0] sr = '0, sout = '0;
    int         scnt = 0;
    logic       force_nf = 1'b0;
    always @(negedge clk) begin
        if (reset) scnt <= 0;
        else if (sh_write) begin sr <= sh_data; scnt <= 8; end
        else if (sh_clk) begin
            sout <= {sout[6:0], sr[7]};
            sr   <= {sr[6:0], 1'b0};
            scnt <= scnt - 1;
        end
    end
    assign sh_empty = !force_nf && scnt == 0;

    logic [1:0] rdy_a [256];
    logic       wr_a [256], clk_a [256], busy_a [256], err_a [256], w1_a [256], c1_a [256];
    logic [7:0] dat_a [256];
    logic [0:0] gid_a [256];
    always @(negedge clk) if (cyc >= 0 && cyc < 256) begin
        rdy_a[cyc] = req_ready; wr_a[cyc] = sh_write; clk_a[cyc] = sh_clk;
        busy_a[cyc] = busy; err_a[cyc] = err; dat_a[cyc] = sh_data;
        gid_a[cyc] = grant_id; w1_a[cyc] = w1; c1_a[cyc] = c1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic start;
        reset = 1'b1; req_valid = '0; force_nf = 1'b0; cyc = -1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; cyc = 0;
    endtask

    function automatic logic [63:0] pat(input int sel, input int a, input int b);
        logic [63:0] p = '0;
        for (int c = a; c <= b; c++)
            p[c] = sel == 0 ? clk_a[c] : sel == 1 ? wr_a[c] : sel == 2 ? busy_a[c] :
                   sel == 3 ? w1_a[c] : c1_a[c];
        return p;
    endfunction

    function automatic int cnt(input int sel, input int a, input int b);
        int s = 0;
        for (int c = a; c <= b; c++)
            s += sel == 0 ? int'(clk_a[c]) : sel == 1 ? int'(wr_a[c]) :
                 sel == 4 ? int'(c1_a[c]) : int'(rdy_a[c] != 0);
        return s;
    endfunction

    logic [63:0] exp_v;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_outs", {sh_data, sh_write, sh_clk, busy, err}, 0);
        check("rst_gid", grant_id, 1);

        // single frame from requester 0
        start();
        req_valid = 2'b01; req_data = 16'h00A5;
        goto(1); req_valid = '0; req_data = 16'hFFFF;
        goto(38);
        check("t1_ready", rdy_a[0], 2'b01);
        check("t1_write", pat(1, 0, 37), 64'h2);
        check("t1_data", dat_a[1], 8'hA5);
        check("t1_gid", gid_a[1], 0);
        exp_v = '0;
        for (int k = 1; k <= 8; k++) exp_v[1 + 4*k] = 1'b1;
        check("t1_clk", pat(0, 0, 37), exp_v);
        exp_v = '0;
        for (int c = 1; c <= 36; c++) exp_v[c] = 1'b1;
        check("t1_busy", pat(2, 0, 37), exp_v);
        check("t1_shout", sout, 8'hA5);
        check("t1_err", err_a[37], 0);

        // both requesters held: alternating grants every 37 cycles
        start();
        req_valid = 2'b11; req_data = 16'h3C5A;
        goto(113);
        req_valid = '0;
        check("t2_g0", rdy_a[0], 2'b01);
        check("t2_g1", rdy_a[37], 2'b10);
        check("t2_g2", rdy_a[74], 2'b01);
        check("t2_g3", rdy_a[111], 2'b10);
        check("t2_ngrants", cnt(5, 0, 112), 4);
        check("t2_gid", {gid_a[38], gid_a[75]}, 2'b10);
        check("t2_data", {dat_a[1], dat_a[38]}, 16'h5A3C);

        // shifter stuck non-empty in first frame
        start();
        force_nf = 1'b1; req_valid = 2'b01; req_data = 16'h00A5;
        goto(1); req_valid = '0;
        goto(37); force_nf = 1'b0; req_valid = 2'b10;
        goto(38); req_valid = '0;
        goto(75);
        check("t3_err34", err_a[34], 0);
        check("t3_err35", err_a[35], 1);
        check("t3_ready", rdy_a[37], 2'b10);
        check("t3_pulses", cnt(0, 38, 74), 8);
        check("t3_sticky", err_a[74], 1);

        // reset in the middle of SHIFT
        start();
        req_valid = 2'b01; req_data = 16'h00A5;
        goto(1); req_valid = '0;
        goto(15); reset = 1'b1;
        goto(16); reset = 1'b0;
        goto(17); req_valid = 2'b11;
        goto(18); req_valid = '0;
        check("t4_busy15", busy_a[15], 1);
        check("t4_outs16", {rdy_a[16], dat_a[16], wr_a[16], clk_a[16], busy_a[16], err_a[16]}, 0);
        check("t4_gid16", gid_a[16], 1);
        check("t4_noclk", cnt(0, 16, 17), 0);
        check("t4_ready17", rdy_a[17], 2'b01);

        // DIV=2, GAP=0 instance with a constant requester
        start();
        goto(61);
        exp_v = '0;
        exp_v[1] = 1'b1; exp_v[20] = 1'b1; exp_v[39] = 1'b1; exp_v[58] = 1'b1;
        check("t5_writes", pat(3, 0, 60), exp_v);
        check("t5_clk_a", cnt(4, 2, 19), 8);
        check("t5_clk_b", cnt(4, 21, 38), 8);
        check("t5_clk_c", cnt(4, 40, 57), 8);

        // request raised only while shifting is ignored
        start();
        req_valid = 2'b01; req_data = 16'h00A5;
        goto(1); req_valid = '0;
        goto(10); req_valid = 2'b10;
        goto(13); req_valid = '0;
        goto(40);
        check("t6_noready", cnt(5, 1, 39), 0);
        check("t6_nowrite", cnt(1, 2, 39), 0);
        check("t6_gid", gid_a[39], 0);
        check("t6_pulses", cnt(0, 0, 39), 8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
